multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style control sequencer for the multi-cycle MIPS datapath variant. It shares one memory port and one ALU across instruction phases.
- Supported opcodes: lw (35), sw (43), beq (4), addi (8) and R-type (0), the same set the single-cycle decoder supports.
- Sequences fetch, decode, execute, memory and writeback states, and stalls on a memory ready handshake.
- Keeps a retired-instruction counter and a sticky illegal-opcode flag for debug.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instruction register bits [31:26], valid from DECODE onward
- zero  input  1  ALU zero flag, used in BRANCH
- mem_ready  input  1  memory completes the current access this cycle
- mem_req  output  1  memory access request
- mem_write  output  1  memory write strobe
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALU out
- ir_write  output  1  instruction register load
- reg_dst  output  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  output  1  writeback select: 0 = ALU out, 1 = memory data
- reg_write  output  1  register file write
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
- alu_op  output  2  00 = add, 01 = sub, 10 = use funct field
- pc_src  output  2  PC next-value select: 00 = ALU result, 01 = ALU out register
- pc_en  output  1  PC load enable
- state  output  4  current state encoding, for debug
- illegal  output  1  sticky flag: an unsupported opcode was decoded
- instr_count  output  CNT_W  number of retired instructions

Behaviour:
- Reset (rst_n low, asynchronous): state = FETCH (0), illegal = 0, instr_count = 0.
  - While rst_n is low, every enable and strobe output is forced to 0: mem_req, mem_write, ir_write, reg_write, pc_en.
  - Select outputs take their FETCH values while rst_n is low.
- State encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10.
- Default output values: every output not listed for a state is 0.
- FETCH:
  - Outputs: mem_req = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00.
  - ir_write = mem_ready and pc_en = mem_ready.
  - Next state: DECODE if mem_ready, otherwise stay in FETCH (the PC does not move).
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (precomputes the branch target).
  - Next state by opcode: 35 or 43 → MEMADR; 0 → EXEC; 4 → BRANCH; 8 → ADDIEX.
  - Any other opcode → FETCH, set illegal = 1, do not increment the counter.
- MEMADR:
  - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - Next state: MEMRD if opcode = 35, MEMWR if opcode = 43.
- MEMRD:
  - Outputs: mem_req = 1, i_or_d = 1.
  - Next state: MEMWB if mem_ready, otherwise hold.
- MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1; next state FETCH.
- MEMWR:
  - Outputs: mem_req = 1, i_or_d = 1, mem_write = mem_ready.
  - Next state: FETCH if mem_ready, otherwise hold.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10; next state ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0; next state FETCH.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01, pc_en = zero.
  - Next state: FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00; next state ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0; next state FETCH.
- Retirement: instr_count increments by 1 on the clock edge leaving any of these:
  - MEMWB, ALUWB, BRANCH or ADDIWB;
  - MEMWR when mem_ready = 1.
- Counter wrap: instr_count wraps modulo 2^CNT_W, with no saturation.
- Cycle counts with no stalls: lw 5, sw 4, R-type 4, addi 4, beq 3. Each stall cycle (mem_ready = 0) adds 1.
- illegal clears only on reset.
- Outputs are combinational from the state register plus the gating inputs mem_ready and zero. There are no glitch-sensitive paths beyond those.
- Reset asserted in any state, including mid-stall: immediate return to FETCH, all write enables drop in the same cycle.
- Unreachable encodings 11–15 → FETCH on the next edge with all enables 0; illegal is not set.

Test Plan:
- Reset release, mem_ready held 1, opcode = 35 → states 0,1,2,3,4,0. reg_write and mem_to_reg are 1 only in state 4. instr_count = 1 after 5 cycles.
- opcode = 43 with mem_ready low for 3 cycles in MEMWR → state 5 holds for 4 cycles. mem_write pulses exactly once, in the cycle mem_ready = 1. Then FETCH, instr_count += 1.
- opcode = 4: with zero = 1, pc_en = 1 and pc_src = 01 in BRANCH; with zero = 0, pc_en = 0. Each takes 3 cycles and retires.
- opcode = 0, then opcode = 8, back to back → R-type: alu_op = 10 in EXEC and reg_dst = 1 in ALUWB. addi: alu_src_b = 10 in ADDIEX and reg_dst = 0 in ADDIWB. instr_count = 2.
- opcode = 6'd2 in DECODE → next state FETCH, illegal = 1 and stays 1, instr_count unchanged.
- rst_n pulsed low during MEMRD with mem_ready = 0 → state = 0 asynchronously, all enables 0, instr_count = 0, illegal = 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Bundle between the multi-cycle control sequencer and its datapath:
// decode inputs, memory handshake and all datapath control strobes.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_write;
  logic             i_or_d;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_src;
  logic             pc_en;
  logic [3:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode,
    input  zero,
    input  mem_ready,
    output mem_req,
    output mem_write,
    output i_or_d,
    output ir_write,
    output reg_dst,
    output mem_to_reg,
    output reg_write,
    output alu_src_a,
    output alu_src_b,
    output alu_op,
    output pc_src,
    output pc_en,
    output state,
    output illegal,
    output instr_count
  );

  modport slave (
    output opcode,
    output zero,
    output mem_ready,
    input  mem_req,
    input  mem_write,
    input  i_or_d,
    input  ir_write,
    input  reg_dst,
    input  mem_to_reg,
    input  reg_write,
    input  alu_src_a,
    input  alu_src_b,
    input  alu_op,
    input  pc_src,
    input  pc_en,
    input  state,
    input  illegal,
    input  instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control sequencer for the multi-cycle MIPS datapath with a
// stalling memory port, retired-instruction counter and illegal flag.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.master bus
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  logic is_lw;
  logic is_sw;
  logic is_r;
  logic is_beq;
  logic is_addi;
  logic bad_op;
  logic retire;

  logic       mem_req_c;
  logic       mem_write_c;
  logic       ir_write_c;
  logic       reg_write_c;
  logic       pc_en_c;
  logic       i_or_d_c;
  logic       reg_dst_c;
  logic       mem_to_reg_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [1:0] alu_op_c;
  logic [1:0] pc_src_c;

  assign is_lw   = (bus.opcode == OP_LW);
  assign is_sw   = (bus.opcode == OP_SW);
  assign is_r    = (bus.opcode == OP_R);
  assign is_beq  = (bus.opcode == OP_BEQ);
  assign is_addi = (bus.opcode == OP_ADDI);
  assign bad_op  = !(is_lw || is_sw || is_r
                   || is_beq || is_addi);

  assign retire = (state_q == MEMWB)
               || (state_q == ALUWB)
               || (state_q == BRANCH)
               || (state_q == ADDIWB)
               || ((state_q == MEMWR) && bus.mem_ready);

  always_comb begin
    state_d = FETCH;
    unique case (state_q)
      FETCH:
        state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: state_d = MEMADR;
          is_r:         state_d = EXEC;
          is_beq:       state_d = BRANCH;
          is_addi:      state_d = ADDIEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:
        state_d = is_lw ? MEMRD : MEMWR;
      MEMRD:
        state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:
        state_d = bus.mem_ready ? FETCH : MEMWR;
      EXEC:    state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == DECODE) && bad_op)
        illegal_q <= 1'b1;
      if (retire)
        cnt_q <= cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    pc_en_c      = 1'b0;
    i_or_d_c     = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    pc_src_c     = 2'b00;
    case (state_q)
      FETCH: begin
        mem_req_c   = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = bus.mem_ready;
        pc_en_c     = bus.mem_ready;
      end
      DECODE:
        alu_src_b_c = 2'b11;
      MEMADR, ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
      end
      MEMRD: begin
        mem_req_c = 1'b1;
        i_or_d_c  = 1'b1;
      end
      MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
      end
      MEMWR: begin
        mem_req_c   = 1'b1;
        i_or_d_c    = 1'b1;
        mem_write_c = bus.mem_ready;
      end
      EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
      end
      ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
      end
      BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b01;
        pc_src_c    = 2'b01;
        pc_en_c     = bus.zero;
      end
      ADDIWB:
        reg_write_c = 1'b1;
      default: ;
    endcase
  end

  // Strobes are gated by rst_n so they drop the instant reset asserts.
  assign bus.mem_req     = mem_req_c & rst_n;
  assign bus.mem_write   = mem_write_c & rst_n;
  assign bus.ir_write    = ir_write_c & rst_n;
  assign bus.reg_write   = reg_write_c & rst_n;
  assign bus.pc_en       = pc_en_c & rst_n;
  assign bus.i_or_d      = i_or_d_c;
  assign bus.reg_dst     = reg_dst_c;
  assign bus.mem_to_reg  = mem_to_reg_c;
  assign bus.alu_src_a   = alu_src_a_c;
  assign bus.alu_src_b   = alu_src_b_c;
  assign bus.alu_op      = alu_op_c;
  assign bus.pc_src      = pc_src_c;
  assign bus.state       = state_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = cnt_q;

endmodule
